// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU sharing controller: data width,
// ALU function codes and the controller state encoding.
package alu_share_ctrl_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] FN_ADD  = 4'd0;   // x + y
    localparam logic [3:0] FN_SUB  = 4'd1;   // x - y
    localparam logic [3:0] FN_RSUB = 4'd2;   // y - x
    localparam logic [3:0] FN_ZERO = 4'd3;   // 0
    localparam logic [3:0] FN_ONE  = 4'd4;   // 1
    localparam logic [3:0] FN_ONES = 4'd5;   // -1
    localparam logic [3:0] FN_NEGX = 4'd6;   // -x
    localparam logic [3:0] FN_NEGY = 4'd7;   // -y
    localparam logic [3:0] FN_NOTX = 4'd8;   // ~x
    localparam logic [3:0] FN_NOTY = 4'd9;   // ~y
    localparam logic [3:0] FN_INCX = 4'd10;  // x + 1
    localparam logic [3:0] FN_INCY = 4'd11;  // y + 1
    localparam logic [3:0] FN_DECX = 4'd12;  // x - 1
    localparam logic [3:0] FN_DECY = 4'd13;  // y - 1
    localparam logic [3:0] FN_AND  = 4'd14;  // x & y
    localparam logic [3:0] FN_OR   = 4'd15;  // x | y

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Purely combinational 16-bit, 16-function ALU. Two's complement,
// modulo 2^16; carries are dropped.
module ALU
    import alu_share_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] ans
);

    // Function decode
    always_comb begin
        ans = '0;
        case (sel)
            FN_ADD:  ans = x + y;
            FN_SUB:  ans = x - y;
            FN_RSUB: ans = y - x;
            FN_ZERO: ans = '0;
            FN_ONE:  ans = 16'd1;
            FN_ONES: ans = '1;
            FN_NEGX: ans = 16'd0 - x;
            FN_NEGY: ans = 16'd0 - y;
            FN_NOTX: ans = ~x;
            FN_NOTY: ans = ~y;
            FN_INCX: ans = x + 16'd1;
            FN_INCY: ans = y + 16'd1;
            FN_DECX: ans = x - 16'd1;
            FN_DECY: ans = y - 16'd1;
            FN_AND:  ans = x & y;
            FN_OR:   ans = x | y;
            default: ans = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin arbiter and sequencer for the shared ALU.
// One operation in flight: accept in IDLE, hold the registered result
// in RESP until the owning requester consumes it.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_x0,
    input  logic [DATA_W-1:0] req_y0,
    input  logic [3:0]        req_sel0,
    input  logic [DATA_W-1:0] req_x1,
    input  logic [DATA_W-1:0] req_y1,
    input  logic [3:0]        req_sel1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              busy
);

    state_t            r_state;
    logic              r_prio;
    logic              r_owner;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_zero;
    logic              r_neg;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_idx;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_ans;

    // Round-robin grant: a lone requester wins, a tie goes to prio
    always_comb begin
        w_grant = req_valid;
        if (req_valid == 2'b11)
            w_grant = r_prio ? 2'b10 : 2'b01;
    end

    // Ready only in IDLE and never while reset is held
    assign req_ready = (r_state == ST_IDLE && !rst) ? w_grant : 2'b00;
    assign w_accept  = |(req_valid & req_ready);
    assign w_idx     = req_ready[1];

    // Operand mux follows the granted requester
    always_comb begin
        w_x   = w_idx ? req_x1   : req_x0;
        w_y   = w_idx ? req_y1   : req_y0;
        w_sel = w_idx ? req_sel1 : req_sel0;
    end

    ALU u_alu (
        .x   (w_x),
        .y   (w_y),
        .sel (w_sel),
        .ans (w_ans)
    );

    // Controller FSM with registered response and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_data      <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data      <= w_ans;
                        r_zero      <= (w_ans == '0);
                        r_neg       <= w_ans[DATA_W-1];
                        r_owner     <= w_idx;
                        r_prio      <= ~w_idx;
                        r_rsp_valid <= w_idx ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Only the owner's rsp_ready matters
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_data;
    assign rsp_zero  = r_zero;
    assign rsp_neg   = r_neg;
    assign busy      = (r_state == ST_RESP);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: hand-computed vectors checked with
// immediate assertions.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_x0, req_y0, req_x1, req_y1;
    logic [3:0]  req_sel0, req_sel1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_neg, busy;

    int errors = 0;
    int checks = 0;

    alu_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_sel0  (req_sel0),
        .req_x1    (req_x1),
        .req_y1    (req_y1),
        .req_sel1  (req_sel1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed results for x=16'h1234, y=16'h00FF, sel 0..15
    logic [15:0] sweep_exp [16] = '{
        16'h1333, 16'h1135, 16'hEECB, 16'h0000,
        16'h0001, 16'hFFFF, 16'hEDCC, 16'hFF01,
        16'hEDCB, 16'hFF00, 16'h1235, 16'h0100,
        16'h1233, 16'h00FE, 16'h0034, 16'h12FF
    };

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_x0 = '0; req_y0 = '0; req_sel0 = '0;
        req_x1 = '0; req_y1 = '0; req_sel1 = '0;

        // Reset state, with both requesters valid to see ready gating
        #2;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data",  rsp_data,  16'h0000);
        chk("rst_flags",     {rsp_zero, rsp_neg}, 2'b00);
        chk("rst_busy",      busy, 1'b0);
        req_valid = 2'b00;
        @(negedge clk); rst = 1'b0;
        tick();

        // Single request from r0: 5 - 3
        req_x0 = 16'h0005; req_y0 = 16'h0003; req_sel0 = 4'd1; req_valid = 2'b01;
        @(negedge clk);
        chk("t1_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data",  rsp_data,  16'h0002);
        chk("t1_flags",     {rsp_zero, rsp_neg}, 2'b00);
        chk("t1_busy",      busy, 1'b1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("t1_consumed", {busy, rsp_valid}, 3'b000);

        // prio is now 1; a reset must restart it at 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tick();

        // Both requesters continuously valid: grants alternate 0,1,0,1
        req_x0 = 16'h7FFF; req_y0 = 16'h0001; req_sel0 = 4'd0;
        req_x1 = 16'h0002; req_y1 = 16'h0001; req_sel1 = 4'd2;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            tick();
            @(negedge clk);
            chk("rr_rsp_valid", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
            chk("rr_rsp_data",  rsp_data,  (k % 2) ? 16'hFFFF : 16'h8000);
            chk("rr_flags",     {rsp_zero, rsp_neg}, 2'b01);
            chk("rr_no_ready",  req_ready, 2'b00);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // r1 AND giving zero, then held response with r0 waiting
        req_x1 = 16'h00F0; req_y1 = 16'h0F00; req_sel1 = 4'd14; req_valid = 2'b10;
        @(negedge clk);
        chk("and_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b01;
        req_x0 = 16'h0001; req_y0 = 16'h0001; req_sel0 = 4'd0;
        req_x1 = 16'hFFFF; req_sel1 = 4'd15;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_req_ready", req_ready, 2'b00);
            chk("hold_rsp_valid", rsp_valid, 2'b10);
            chk("hold_rsp_data",  rsp_data,  16'h0000);
            chk("hold_flags",     {rsp_zero, rsp_neg}, 2'b10);
            tick();
        end
        // Non-owner rsp_ready is ignored
        rsp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nonowner_rsp_valid", rsp_valid, 2'b10);
            chk("nonowner_busy",      busy, 1'b1);
            tick();
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        // Consumed at the last edge: r0 may be accepted at the very next one
        @(negedge clk);
        chk("reaccept_ready", req_ready, 2'b01);
        chk("reaccept_idle",  {busy, rsp_valid}, 3'b000);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("reaccept_data", rsp_data, 16'h0002);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Function sweep from r0
        req_x0 = 16'h1234; req_y0 = 16'h00FF;
        for (int s = 0; s < 16; s++) begin
            req_sel0  = s[3:0];
            req_valid = 2'b01;
            @(negedge clk);
            chk("sweep_ready", req_ready, 2'b01);
            tick();
            req_valid = 2'b00;
            @(negedge clk);
            chk("sweep_data", rsp_data, sweep_exp[s]);
            chk("sweep_flags", {rsp_zero, rsp_neg},
                {(sweep_exp[s] == 16'h0000), sweep_exp[s][15]});
            rsp_ready = 2'b01;
            tick();
            rsp_ready = 2'b00;
        end

        // Asynchronous reset with an r1 response pending
        req_x1 = 16'h0003; req_y1 = 16'h0004; req_sel1 = 4'd0; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        #1;
        chk("pre_rst_rsp_valid", rsp_valid, 2'b10);
        chk("pre_rst_rsp_data",  rsp_data,  16'h0007);
        rst = 1'b1;
        #1;
        chk("async_rsp_valid", rsp_valid, 2'b00);
        chk("async_rsp_data",  rsp_data,  16'h0000);
        chk("async_busy",      busy, 1'b0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_quiet", {busy, rsp_valid}, 3'b000);
        end
        req_x0 = 16'h0000; req_y0 = 16'h0000; req_sel0 = 4'd4;
        req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_prio", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("post_rst_data", {rsp_valid, rsp_data}, {2'b01, 16'h0001});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
